// File: rtl/conv_host_pkg.sv
// Shared constants for the host-side driver of the 2x2 convolution core.
// States, response bit fields and frame geometry live here.
package conv_host_pkg;

    localparam int SETTLE_CYCLES_DEF = 3;
    localparam int N_LANES           = 4;
    localparam int TOG_BIT           = 9;
    localparam int MAX_W             = 9;
    localparam int RESP_W            = MAX_W + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD_W  = 3'd1;
    localparam logic [2:0] ST_LOAD_I  = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

endpackage

// File: rtl/conv_host_driver.sv
// Shifts one frame into the conv core, waits SETTLE_CYCLES, captures {toggle,max}.
// Latency accept->rsp_valid: 4+SETTLE_CYCLES+2 cycles (+4 with weight reload).
// Backpressure: req_ready only in IDLE; response held until rsp_ready.
module conv_host_driver
    import conv_host_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_inputs,
    input  logic [31:0]       req_weights,
    input  logic              req_load_w,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [MAX_W-1:0]  rsp_max,
    output logic              rsp_err,
    output logic [7:0]        conv_data,
    output logic              conv_wsel,
    output logic              conv_rd,
    input  logic [RESP_W-1:0] conv_resp
);

    logic [2:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       settle_q, settle_d;
    logic [31:0]      in_q, in_d;
    logic [31:0]      w_q, w_d;
    logic [MAX_W-1:0] max_q, max_d;
    logic             err_q, err_d;
    logic             tog_q, tog_nxt;
    logic             tog_rep_q, tog_rep_d;

    // Core shifts an input byte on any cycle without rd/wsel, so rd idles high.
    always_comb begin
        conv_rd   = 1'b1;
        conv_wsel = 1'b0;
        conv_data = 8'h00;
        if (rst_n) begin
            if (state_q == ST_LOAD_W) begin
                conv_rd   = 1'b0;
                conv_wsel = 1'b1;
                conv_data = w_q[cnt_q*8 +: 8];
            end else if (state_q == ST_LOAD_I) begin
                conv_rd   = 1'b0;
                conv_data = in_q[cnt_q*8 +: 8];
            end
        end
    end

    assign req_ready = rst_n && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_max   = max_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        in_d      = in_q;
        w_d       = w_q;
        max_d     = max_q;
        err_d     = err_q;
        tog_nxt   = tog_q ^ conv_rd;
        // tog_rep_q: toggle value the core is presenting on conv_resp this cycle
        tog_rep_d = tog_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    in_d    = req_inputs;
                    w_d     = req_weights;
                    cnt_d   = 2'd0;
                    state_d = req_load_w ? ST_LOAD_W : ST_LOAD_I;
                end
            end
            ST_LOAD_W: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(N_LANES - 1)) state_d = ST_LOAD_I;
            end
            ST_LOAD_I: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(N_LANES - 1)) begin
                    settle_d = 8'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                settle_d = settle_q + 8'd1;
                if (settle_q == 8'(SETTLE_CYCLES - 1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                max_d   = conv_resp[MAX_W-1:0];
                err_d   = (conv_resp[TOG_BIT] != tog_rep_q);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            settle_q  <= 8'd0;
            in_q      <= 32'd0;
            w_q       <= 32'd0;
            max_q     <= '0;
            err_q     <= 1'b0;
            tog_q     <= 1'b0;
            tog_rep_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            in_q      <= in_d;
            w_q       <= w_d;
            max_q     <= max_d;
            err_q     <= err_d;
            tog_q     <= tog_nxt;
            tog_rep_q <= tog_rep_d;
        end
    end

endmodule

// File: tb/tb_conv_host_driver.sv
// Directed bench for conv_host_driver paired with a behavioural 2x2 conv core.
module tb_conv_host_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load_w;
    logic [31:0] req_inputs, req_weights;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [8:0]  rsp_max;
    logic [7:0]  conv_data;
    logic        conv_wsel, conv_rd;
    logic [9:0]  conv_resp;
    logic        inv;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    conv_host_driver dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inputs(req_inputs), .req_weights(req_weights), .req_load_w(req_load_w),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_max(rsp_max), .rsp_err(rsp_err),
        .conv_data(conv_data), .conv_wsel(conv_wsel), .conv_rd(conv_rd),
        .conv_resp(conv_resp)
    );

    // Behavioural core: byte shift regs, 1-cycle dot product, 1-cycle running max.
    logic [31:0] c_in, c_w, c_sum, c_max;
    logic        c_tog;
    logic [9:0]  c_resp;

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < 4; i++) s = s + 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            c_in <= 0; c_w <= 0; c_sum <= 0; c_max <= 0; c_tog <= 0; c_resp <= 0;
        end else begin
            if (conv_rd) begin
                c_resp <= {c_tog, c_max[8:0]};
                c_tog  <= ~c_tog;
            end else if (conv_wsel) begin
                c_w <= {conv_data, c_w[31:8]};
            end else begin
                c_in <= {conv_data, c_in[31:8]};
            end
            c_sum <= dot(c_in, c_w);
            if (c_sum > c_max) c_max <= c_sum;
        end
    end

    assign conv_resp = {c_resp[9] ^ inv, c_resp[8:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic frame(input string tag, input logic [31:0] w, input logic [31:0] in,
                         input logic lw, input int inv_at, input int hold,
                         input int exp_lat, input logic [8:0] exp_max, input logic exp_err,
                         input bit chk_nowsel);
        int lat;
        logic saw_w;
        @(negedge clk);
        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_weights = w; req_inputs = in; req_load_w = lw;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        saw_w = 1'b0;
        while (!rsp_valid && lat < 40) begin
            saw_w = saw_w | conv_wsel;
            if (lat == 1) chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
            inv = (lat == inv_at);
            @(negedge clk);
            lat++;
        end
        inv = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rsp_max"}, 32'(rsp_max), 32'(exp_max));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
        if (chk_nowsel) chk({tag, "_no_wsel"}, 32'(saw_w), 32'd0);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_max"}, 32'(rsp_max), 32'(exp_max));
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
            chk({tag, "_hold_rd"}, 32'(conv_rd), 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_load_w = 1'b0; rsp_ready = 1'b0;
        req_inputs = 32'd0; req_weights = 32'd0; inv = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_max", 32'(rsp_max), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_conv_data", 32'(conv_data), 32'd0);
        chk("rst_conv_wsel", 32'(conv_wsel), 32'd0);
        chk("rst_conv_rd", 32'(conv_rd), 32'd1);
        rst_n = 1'b1;

        // Weights of 1, inputs 1..4: sum 10.
        frame("t1", 32'h01010101, 32'h04030201, 1'b1, 0, 0, 13, 9'd10, 1'b0, 1'b0);
        // Zero inputs with kept weights: running max holds 10, no weight shifts.
        frame("t2", 32'h0, 32'h0, 1'b0, 0, 0, 9, 9'd10, 1'b0, 1'b1);
        // 4*255*255 = 260100 -> low 9 bits = 4; response held 5 cycles.
        frame("t3", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 5, 13, 9'd4, 1'b0, 1'b0);
        // Corrupted toggle during CAPTURE (cycle 8 after accept) then clean frame.
        frame("t5a", 32'h0, 32'h0, 1'b0, 8, 0, 9, 9'd4, 1'b1, 1'b1);
        frame("t5b", 32'h0, 32'h0, 1'b0, 0, 0, 9, 9'd4, 1'b0, 1'b1);

        // Reset mid-frame at LOAD_I byte 2.
        @(negedge clk);
        req_valid = 1'b1; req_weights = 32'h01010101; req_inputs = 32'h04030201; req_load_w = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_load_i_rd", 32'(conv_rd), 32'd0);
        chk("t6_load_i_wsel", 32'(conv_wsel), 32'd0);
        chk("t6_load_i_byte2", 32'(conv_data), 32'h03);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                seen = seen | rsp_valid;
                @(negedge clk);
            end
            chk("t6_no_rsp", 32'(seen), 32'd0);
        end
        chk("t6_idle_ready", 32'(req_ready), 32'd1);
        frame("t6", 32'h01010101, 32'h04030201, 1'b1, 0, 0, 13, 9'd10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
